// File: rtl/seq_mul_param_pkg.sv
// Shared types for the parametrised sequential Booth multiplier.
package seq_mul_pkg;
    localparam int MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/seq_mul_param_if.sv
// Operand/result handshake bundle for seq_mul_param.
interface seq_mul_param_if #(parameter int WIDTH = 16);
    logic [WIDTH-1:0]   q;
    logic [WIDTH-1:0]   m;
    logic               sgn;
    logic               src_valid;
    logic               src_ready;
    logic [2*WIDTH-1:0] p;
    logic               dest_valid;
    logic               dest_ready;

    modport slave (
        input  q, m, sgn, src_valid, dest_ready,
        output src_ready, p, dest_valid
    );

    modport master (
        output q, m, sgn, src_valid, dest_ready,
        input  src_ready, p, dest_valid
    );
endinterface

// File: rtl/seq_mul_param_booth_step.sv
// One radix-2 Booth iteration on (WIDTH+1)-bit operands: add/sub then arithmetic shift.
module booth_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0] acc,
    input  logic [WIDTH:0] q,
    input  logic           q_m1,
    input  logic [WIDTH:0] m,
    output logic [WIDTH:0] acc_nxt,
    output logic [WIDTH:0] q_nxt,
    output logic           q_m1_nxt
);
    logic [WIDTH:0] sum;

    always_comb begin
        sum = acc;
        case ({q[0], q_m1})
            2'b10:   sum = acc - m;
            2'b01:   sum = acc + m;
            default: sum = acc;
        endcase
    end

    // Shift {sum, q, q_m1} right by one, replicating the sign of sum.
    assign acc_nxt  = {sum[WIDTH], sum[WIDTH:1]};
    assign q_nxt    = {sum[0], q[WIDTH:1]};
    assign q_m1_nxt = q[0];
endmodule

// File: rtl/seq_mul_param.sv
// Sequential radix-2 Booth multiplier, WIDTH-bit operands, per-transaction signed/unsigned.
// Optional ZERO_SKIP_EN: a zero operand completes straight to DONE on the accept edge.
module seq_mul_param
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    seq_mul_param_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 2);

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     acc, qr, mr;
    logic               qm1;
    logic [WIDTH:0]     acc_s, q_s;
    logic               qm1_s;
    logic               last, skip;
    logic [2*WIDTH-1:0] p_r;

    // One extra bit lets unsigned operands run through the signed Booth recoding.
    function automatic logic [WIDTH:0] ext(input logic [WIDTH-1:0] v, input logic s);
        return {s & v[WIDTH-1], v};
    endfunction

    booth_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .q        (qr),
        .q_m1     (qm1),
        .m        (mr),
        .acc_nxt  (acc_s),
        .q_nxt    (q_s),
        .q_m1_nxt (qm1_s)
    );

    assign last = (cnt == CW'(1));

`ifdef ZERO_SKIP_EN
    assign skip = (bus.q == '0) || (bus.m == '0);
`else
    assign skip = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.src_valid)  state_nxt = skip ? DONE : BUSY;
            BUSY:    if (last)           state_nxt = DONE;
            DONE:    if (bus.dest_ready) state_nxt = IDLE;
            default:                     state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.src_ready  = 1'b0;
        bus.dest_valid = 1'b0;
        case (state)
            IDLE:    bus.src_ready  = 1'b1;
            DONE:    bus.dest_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
            qr  <= '0;
            mr  <= '0;
            qm1 <= 1'b0;
            cnt <= '0;
            p_r <= '0;
        end else begin
            case (state)
                IDLE: if (bus.src_valid) begin
                    acc <= '0;
                    qm1 <= 1'b0;
                    qr  <= ext(bus.q, bus.sgn);
                    mr  <= ext(bus.m, bus.sgn);
                    cnt <= CW'(WIDTH + 1);
                    if (skip) p_r <= '0;
                end
                BUSY: begin
                    acc <= acc_s;
                    qr  <= q_s;
                    qm1 <= qm1_s;
                    cnt <= cnt - CW'(1);
                    // Low 2*WIDTH bits of the (2*WIDTH+2)-bit {acc,q} product.
                    if (last) p_r <= {acc_s[WIDTH-2:0], q_s};
                end
                default: ;
            endcase
        end
    end

    assign bus.p = p_r;
endmodule

// File: tb/tb_seq_mul_param.sv
// Randomised self-checking bench for seq_mul_param against an arithmetic product model.
module tb_seq_mul_param;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    seq_mul_param_if #(.WIDTH(W)) bus();
    seq_mul_param #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks = 0;
    int errors = 0;

    function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic s);
        longint x, y, pr;
        if (s) begin
            x = longint'($signed(a));
            y = longint'($signed(b));
        end else begin
            x = longint'(a);
            y = longint'(b);
        end
        pr = x * y;
        return pr[2*W-1:0];
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(W-1){1'b0}}};
            3:       return {1'b0, {(W-1){1'b1}}};
            4:       return W'(1);
            default: return W'($urandom);
        endcase
    endfunction

    // Drives one transaction from an IDLE point (posedge+1) through its destination handshake.
    task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                           input bit rnd_ready, output int lat, output logic [2*W-1:0] got);
        int guard;
        bit hs;
        bus.q = a; bus.m = b; bus.sgn = s; bus.src_valid = 1'b1; bus.dest_ready = 1'b0;
        guard = 0;
        while (!bus.src_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        @(posedge clk); #1;
        bus.src_valid = 1'b0;
        bus.q = W'($urandom); bus.m = W'($urandom); bus.sgn = 1'($urandom);
        lat = 0;
        while (!bus.dest_valid && lat < 100) begin
            if (rnd_ready) bus.dest_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1; lat++;
        end
        got = bus.p;
        guard = 0;
        while (bus.dest_valid && guard < 200) begin
            hs = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.dest_ready = hs;
            @(posedge clk); #1; guard++;
            if (hs) break;
            checks++;
            if (bus.p !== got || bus.dest_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold: p=%h dv=%b required p=%h dv=1", bus.p, bus.dest_valid, got);
            end
        end
        bus.dest_ready = 1'b0;
        checks++;
        if (bus.dest_valid !== 1'b0 || bus.src_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_handshake: dv=%b sr=%b required dv=0 sr=1", bus.dest_valid, bus.src_ready);
        end
    endtask

    task automatic test_reset();
        bus.src_valid = 1'b0; bus.dest_ready = 1'b0; bus.q = '0; bus.m = '0; bus.sgn = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk); #1;
        checks++;
        if (bus.src_ready !== 1'b1) begin
            errors++; $display("FAIL reset_src_ready: got %b required 1", bus.src_ready);
        end
        checks++;
        if (bus.dest_valid !== 1'b0) begin
            errors++; $display("FAIL reset_dest_valid: got %b required 0", bus.dest_valid);
        end
        checks++;
        if (bus.p !== '0) begin
            errors++; $display("FAIL reset_p: got %h required 0", bus.p);
        end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat;
        logic [2*W-1:0] got;
        run_txn(16'd1, 16'd3, 1'b1, 1'b0, lat, got);
        checks++;
        if (got !== 32'h0000_0003) begin
            errors++; $display("FAIL basic_p: got %h required 00000003", got);
        end
        checks++;
        if (lat != W + 1) begin
            errors++; $display("FAIL basic_latency: got %0d required %0d", lat, W + 1);
        end
    endtask

    task automatic test_corners();
        int lat;
        logic [2*W-1:0] got;
        run_txn(16'h8000, 16'h8000, 1'b1, 1'b0, lat, got);
        checks++;
        if (got !== 32'h4000_0000) begin
            errors++; $display("FAIL corner_sneg_sq: got %h required 40000000", got);
        end
        run_txn(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, lat, got);
        checks++;
        if (got !== 32'hFFFE_0001) begin
            errors++; $display("FAIL corner_umax_sq: got %h required fffe0001", got);
        end
        run_txn(16'hFFFF, 16'd7, 1'b1, 1'b0, lat, got);
        checks++;
        if (got !== 32'hFFFF_FFF9) begin
            errors++; $display("FAIL corner_neg1_x7: got %h required fffffff9", got);
        end
        run_txn(16'h8000, 16'h7FFF, 1'b1, 1'b0, lat, got);
        checks++;
        if (got !== 32'hC000_8000) begin
            errors++; $display("FAIL corner_min_x_max: got %h required c0008000", got);
        end
    endtask

    task automatic test_ignore();
        int delivered;
        bus.q = 16'd2; bus.m = 16'd7; bus.sgn = 1'b0; bus.src_valid = 1'b1; bus.dest_ready = 1'b0;
        @(posedge clk); #1;
        bus.src_valid = 1'b0;
        for (int i = 0; i < W + 12; i++) begin
            checks++;
            if (bus.src_ready !== 1'b0) begin
                errors++; $display("FAIL ignore_src_ready: cyc %0d got %b required 0", i, bus.src_ready);
            end
            if (i >= W + 1) begin
                checks++;
                if (bus.dest_valid !== 1'b1 || bus.p !== 32'd14) begin
                    errors++;
                    $display("FAIL ignore_done_hold: cyc %0d dv=%b p=%h required dv=1 p=0000000e",
                             i, bus.dest_valid, bus.p);
                end
            end else begin
                checks++;
                if (bus.dest_valid !== 1'b0) begin
                    errors++; $display("FAIL ignore_busy_dv: cyc %0d got %b required 0", i, bus.dest_valid);
                end
            end
            bus.src_valid = 1'($urandom_range(0, 1));
            bus.q = W'($urandom); bus.m = W'($urandom); bus.sgn = 1'($urandom);
            @(posedge clk); #1;
        end
        bus.src_valid = 1'b0;
        bus.dest_ready = 1'b1;
        delivered = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus.dest_valid && bus.dest_ready) delivered++;
            @(posedge clk); #1;
        end
        bus.dest_ready = 1'b0;
        checks++;
        if (delivered != 1) begin
            errors++; $display("FAIL ignore_one_result: got %0d results required 1", delivered);
        end
    endtask

    task automatic test_back_to_back();
        logic [2*W-1:0] expq[$];
        logic [2*W-1:0] e;
        int last_acc, n_acc;
        bit acc_now;
        last_acc = -1; n_acc = 0;
        bus.dest_ready = 1'b1; bus.src_valid = 1'b1;
        bus.q = W'($urandom_range(1, 16'hFFFF)); bus.m = W'($urandom_range(1, 16'hFFFF));
        bus.sgn = 1'($urandom);
        for (int cyc = 0; cyc < 19 * 8 + 200; cyc++) begin
            if (cyc >= 19 * 8) bus.src_valid = 1'b0;
            if (cyc >= 19 * 8 && expq.size() == 0 && bus.src_ready) break;
            acc_now = bus.src_ready && bus.src_valid;
            if (bus.dest_valid) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++; $display("FAIL b2b_unexpected: p=%h with no accepted operands", bus.p);
                end else begin
                    e = expq.pop_front();
                    if (bus.p !== e) begin
                        errors++; $display("FAIL b2b_p: got %h required %h", bus.p, e);
                    end
                end
            end
            if (acc_now) begin
                expq.push_back(ref_prod(bus.q, bus.m, bus.sgn));
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc != W + 3) begin
                        errors++;
                        $display("FAIL b2b_interval: got %0d required %0d", cyc - last_acc, W + 3);
                    end
                end
                last_acc = cyc;
                n_acc++;
            end
            @(posedge clk); #1;
            if (acc_now) begin
                bus.q = W'($urandom_range(1, 16'hFFFF)); bus.m = W'($urandom_range(1, 16'hFFFF));
                bus.sgn = 1'($urandom);
            end
        end
        bus.src_valid = 1'b0; bus.dest_ready = 1'b0;
        checks++;
        if (expq.size() != 0 || n_acc < 7) begin
            errors++; $display("FAIL b2b_drain: pending %0d accepts %0d required 0 and >=7", expq.size(), n_acc);
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        logic [2*W-1:0] got;
        bus.q = 16'h1234; bus.m = 16'h0055; bus.sgn = 1'b0; bus.src_valid = 1'b1;
        @(posedge clk); #1;
        bus.src_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if (bus.dest_valid !== 1'b0 || bus.p !== '0 || bus.src_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_state: dv=%b p=%h sr=%b required dv=0 p=0 sr=1",
                     bus.dest_valid, bus.p, bus.src_ready);
        end
        #1 rst = 1'b1;
        @(posedge clk); #1;
        run_txn(16'd3, 16'd5, 1'b0, 1'b0, lat, got);
        checks++;
        if (got !== 32'd15 || lat != W + 1) begin
            errors++; $display("FAIL abort_next: p=%h lat=%0d required p=0000000f lat=%0d", got, lat, W + 1);
        end
    endtask

    task automatic test_zero_skip();
        int lat, exp_lat;
        logic [2*W-1:0] got;
`ifdef ZERO_SKIP_EN
        exp_lat = 0;  // valid straight after the accept edge
`else
        exp_lat = W + 1;
`endif
        run_txn(16'd0, 16'd20, 1'b1, 1'b0, lat, got);
        checks++;
        if (got !== '0 || lat != exp_lat) begin
            errors++; $display("FAIL zero_q: p=%h lat=%0d required p=0 lat=%0d", got, lat, exp_lat);
        end
        run_txn(16'd20, 16'd0, 1'b0, 1'b0, lat, got);
        checks++;
        if (got !== '0 || lat != exp_lat) begin
            errors++; $display("FAIL zero_m: p=%h lat=%0d required p=0 lat=%0d", got, lat, exp_lat);
        end
    endtask

    task automatic test_random();
        int lat;
        logic [2*W-1:0] got, e;
        logic [W-1:0] a, b;
        logic s;
        for (int n = 0; n < 400; n++) begin
            a = pick(); b = pick(); s = 1'($urandom);
            e = ref_prod(a, b, s);
            run_txn(a, b, s, 1'b1, lat, got);
            checks++;
            if (got !== e) begin
                errors++; $display("FAIL random_p: %h*%h sgn=%b got %h required %h", a, b, s, got, e);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_ignore();
        test_back_to_back();
        test_reset_abort();
        test_zero_skip();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
